sdram_host_arbiter: RTL and testbench

SDRAM_HOST_ARBITER -- requirements
Module: sdram_host_arbiter

---
 rtl/sdram_host_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter
// Shares one SDRAM controller between two word-oriented hosts (A and B) and
// a built-in refresh scheduler. One transfer is in flight at a time; pending
// refresh always wins over host traffic.
//
// Configuration macro: SDRAM_ARB_RR_EN
//   defined   - round-robin between A and B (tie goes to the pointer, which
//               moves to the other host after every host grant)
//   undefined - fixed priority, A always wins over B
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   a_addr/b_addr [23:0]        host word address
//   a_din/b_din   [15:0]        host write data
//   a_rd_rq/a_wr_rq, b_*        level requests, held until the matching ack
//   a_ack/b_ack                 one-cycle completion pulse
//   a_dout/b_dout [15:0]        read data, valid from ack onward
//   ctl_addr/ctl_din            latched command address/data to controller
//   ctl_read_rq/ctl_write_rq/ctl_rfsh_rq  one-cycle command strobes
//   ctl_dout [15:0], ctl_busy   controller read data and busy
//   rfsh_overflow               sticky: refresh debt hit RFSH_MAX and another tick came
module sdram_host_arbiter #(
    parameter int RFSH_PERIOD = 499,
    parameter int RFSH_MAX    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] a_addr,
    input  logic [15:0] a_din,
    input  logic        a_rd_rq,
    input  logic        a_wr_rq,
    output logic        a_ack,
    output logic [15:0] a_dout,
    input  logic [23:0] b_addr,
    input  logic [15:0] b_din,
    input  logic        b_rd_rq,
    input  logic        b_wr_rq,
    output logic        b_ack,
    output logic [15:0] b_dout,
    output logic [23:0] ctl_addr,
    output logic [15:0] ctl_din,
    output logic        ctl_read_rq,
    output logic        ctl_write_rq,
    output logic        ctl_rfsh_rq,
    input  logic [15:0] ctl_dout,
    input  logic        ctl_busy,
    output logic        rfsh_overflow
);

    localparam int TW = (RFSH_PERIOD > 2) ? $clog2(RFSH_PERIOD) : 1;
    localparam int PW = (RFSH_MAX > 1) ? $clog2(RFSH_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_RFSH} src_t;

    state_t        state;
    src_t          src;
    logic          op_read;
    logic [TW-1:0] timer;
    logic [PW-1:0] pending;

    logic a_req;
    logic b_req;
    logic pick_b;
    logic tick;
    logic rfsh_done;

    assign a_req = a_rd_rq | a_wr_rq;
    assign b_req = b_rd_rq | b_wr_rq;

`ifdef SDRAM_ARB_RR_EN
    // rr_ptr = 1 means B owns the tie
    logic rr_ptr;
    assign pick_b = b_req && (!a_req || rr_ptr);
`else
    assign pick_b = b_req && !a_req;
`endif

    assign tick      = (timer == TW'(RFSH_PERIOD - 1));
    assign rfsh_done = (state == WAIT_DONE) && !ctl_busy && (src == SRC_RFSH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            src           <= SRC_A;
            op_read       <= 1'b0;
            timer         <= '0;
            pending       <= '0;
            rfsh_overflow <= 1'b0;
            ctl_addr      <= '0;
            ctl_din       <= '0;
            ctl_read_rq   <= 1'b0;
            ctl_write_rq  <= 1'b0;
            ctl_rfsh_rq   <= 1'b0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            a_dout        <= '0;
            b_dout        <= '0;
`ifdef SDRAM_ARB_RR_EN
            rr_ptr        <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            timer <= tick ? '0 : timer + TW'(1);

            // A tick and a refresh completion in the same cycle cancel out
            if (tick && !rfsh_done) begin
                if (pending == PW'(RFSH_MAX))
                    rfsh_overflow <= 1'b1;
                else
                    pending <= pending + PW'(1);
            end else if (!tick && rfsh_done) begin
                pending <= pending - PW'(1);
            end

            case (state)
                IDLE: begin
                    if (!ctl_busy) begin
                        if (pending != '0) begin
                            src         <= SRC_RFSH;
                            op_read     <= 1'b0;
                            ctl_rfsh_rq <= 1'b1;
                            state       <= ISSUE;
                        end else if (a_req || b_req) begin
                            src      <= pick_b ? SRC_B : SRC_A;
                            ctl_addr <= pick_b ? b_addr : a_addr;
                            ctl_din  <= pick_b ? b_din : a_din;
                            // write takes precedence when both strobes are up
                            if (pick_b ? b_wr_rq : a_wr_rq) begin
                                ctl_write_rq <= 1'b1;
                                op_read      <= 1'b0;
                            end else begin
                                ctl_read_rq  <= 1'b1;
                                op_read      <= 1'b1;
                            end
`ifdef SDRAM_ARB_RR_EN
                            rr_ptr <= ~pick_b;
`endif
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    ctl_read_rq  <= 1'b0;
                    ctl_write_rq <= 1'b0;
                    ctl_rfsh_rq  <= 1'b0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (ctl_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!ctl_busy) begin
                        state <= IDLE;
                        if (src == SRC_A) begin
                            a_ack <= 1'b1;
                            if (op_read)
                                a_dout <= ctl_dout;
                        end else if (src == SRC_B) begin
                            b_ack <= 1'b1;
                            if (op_read)
                                b_dout <= ctl_dout;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter
// Scoreboard bench: host requests push their expected controller command and
// completion data into per-host queues; a monitor checks every grant, refresh
// strobe and ack against those queues and an arithmetic refresh-debt model.
// A second instance with a short refresh period exercises saturation.
`timescale 1ns/1ps
module tb_sdram_host_arbiter;

    localparam int P1 = 20;
    localparam int P2 = 4;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [23:0] addr [2];
    logic [15:0] din [2];
    logic        rd_rq [2];
    logic        wr_rq [2];
    logic        a_ack, b_ack;
    logic [15:0] a_dout, b_dout;
    logic [23:0] ctl_addr;
    logic [15:0] ctl_din, ctl_dout;
    logic        ctl_read_rq, ctl_write_rq, ctl_rfsh_rq, ctl_busy, rfsh_overflow;

    // second instance: everything idle except busy and reset
    logic        rst2_n = 1'b0;
    logic        busy2 = 1'b0;
    logic [23:0] zero24 = '0;
    logic [15:0] zero16 = '0;
    logic        zero1 = 1'b0;
    logic        a_ack2, b_ack2, rd2, wr2, rf2, ovf2;
    logic [15:0] a_dout2, b_dout2, din2;
    logic [23:0] addr2;

    sdram_host_arbiter #(.RFSH_PERIOD(P1), .RFSH_MAX(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(addr[0]), .a_din(din[0]), .a_rd_rq(rd_rq[0]), .a_wr_rq(wr_rq[0]),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_addr(addr[1]), .b_din(din[1]), .b_rd_rq(rd_rq[1]), .b_wr_rq(wr_rq[1]),
        .b_ack(b_ack), .b_dout(b_dout),
        .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_read_rq(ctl_read_rq),
        .ctl_write_rq(ctl_write_rq), .ctl_rfsh_rq(ctl_rfsh_rq),
        .ctl_dout(ctl_dout), .ctl_busy(ctl_busy), .rfsh_overflow(rfsh_overflow)
    );

    sdram_host_arbiter #(.RFSH_PERIOD(P2), .RFSH_MAX(7)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .a_addr(zero24), .a_din(zero16), .a_rd_rq(zero1), .a_wr_rq(zero1),
        .a_ack(a_ack2), .a_dout(a_dout2),
        .b_addr(zero24), .b_din(zero16), .b_rd_rq(zero1), .b_wr_rq(zero1),
        .b_ack(b_ack2), .b_dout(b_dout2),
        .ctl_addr(addr2), .ctl_din(din2), .ctl_read_rq(rd2),
        .ctl_write_rq(wr2), .ctl_rfsh_rq(rf2),
        .ctl_dout(zero16), .ctl_busy(busy2), .rfsh_overflow(ovf2)
    );

    int   checks = 0;
    int   fails = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   grant_cnt [2] = '{0, 0};
    int   ack_cnt [2] = '{0, 0};
    int   ack_log[$];
    int   wr_pulses = 0;
    int   rfsh_issued = 0;
    int   n = 0;

    logic [15:0] last_dout [2] = '{16'h0, 16'h0};
    logic [15:0] prev_dout [2];
    bit   hs_active [2] = '{0, 0};
    bit   hs_drop [2] = '{0, 0};
    int   hs_idle [2] = '{0, 0};
    int   hs_wait [2] = '{0, 0};
    int   hs_gnt [2] = '{0, 0};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int h);
        return (h == 0) ? qa.size() : qb.size();
    endfunction

    // Reference controller: busy rises the cycle after a strobe, lasts 6 cycles
    int cm_cnt = 0;
    bit cm_pend = 0;
    bit cm_rd = 0;
    initial begin
        ctl_busy = 1'b0;
        ctl_dout = '0;
        forever begin
            @(negedge clk);
            if (cm_pend) begin
                ctl_busy = 1'b1;
                cm_cnt   = 6;
                ctl_dout = cm_rd ? (ctl_addr[15:0] ^ 16'hA5A5) : 16'($urandom);
                cm_pend  = 0;
            end else if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0)
                    ctl_busy = 1'b0;
            end
            if (ctl_read_rq || ctl_write_rq || ctl_rfsh_rq) begin
                cm_pend = 1;
                cm_rd   = ctl_read_rq;
            end
        end
    end

    // Monitor: n counts clock edges since reset; tick k lands on edge k*P1
    initial begin
        exp_t        e;
        int          w, inflight, gnt_n, rr_next;
        bit          prev_rq, a_req, b_req;
        logic [23:0] held_addr;
        logic [15:0] held_din;
        inflight = -1; gnt_n = 0; rr_next = 0; prev_rq = 0;
        held_addr = '0; held_din = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                n = 0; rfsh_issued = 0; inflight = -1; rr_next = 0; prev_rq = 0;
                if (a_ack || b_ack) checkOutput("ack_during_reset", 1, 0);
            end else begin
                n++;
                if (ctl_read_rq || ctl_write_rq || ctl_rfsh_rq) begin
                    checkOutput("rq_onehot", 32'(ctl_read_rq) + 32'(ctl_write_rq) + 32'(ctl_rfsh_rq), 1);
                    checkOutput("rq_one_cycle", 32'(prev_rq), 0);
                end
                if (ctl_rfsh_rq) begin
                    checkOutput("rfsh_has_debt", 32'(rfsh_issued < (n - 1) / P1), 1);
                    rfsh_issued++;
                    inflight = 2;
                end else if (ctl_read_rq || ctl_write_rq) begin
                    wr_pulses += 32'(ctl_write_rq);
                    a_req = rd_rq[0] | wr_rq[0];
                    b_req = rd_rq[1] | wr_rq[1];
`ifdef SDRAM_ARB_RR_EN
                    w = (a_req && b_req) ? rr_next : (a_req ? 0 : (b_req ? 1 : -1));
`else
                    w = a_req ? 0 : (b_req ? 1 : -1);
`endif
                    checkOutput("rfsh_priority", 32'(rfsh_issued), 32'((n - 1) / P1));
                    if (w < 0 || qsize(w) == 0) begin
                        checkOutput("grant_without_request", 0, 1);
                    end else begin
                        e = (w == 0) ? qa[0] : qb[0];
                        checkOutput(w == 0 ? "grant_a_wr" : "grant_b_wr", 32'(ctl_write_rq), 32'(e.wr));
                        checkOutput(w == 0 ? "grant_a_addr" : "grant_b_addr", 32'(ctl_addr), 32'(e.addr));
                        checkOutput(w == 0 ? "grant_a_din" : "grant_b_din", 32'(ctl_din), 32'(e.din));
                        grant_cnt[w]++;
                        inflight  = w;
                        gnt_n     = n;
                        held_addr = ctl_addr;
                        held_din  = ctl_din;
                        rr_next   = 1 - w;
                    end
                end
                prev_rq = ctl_read_rq | ctl_write_rq | ctl_rfsh_rq;
                for (int h = 0; h < 2; h++) begin
                    if ((h == 0) ? a_ack : b_ack) begin
                        ack_cnt[h]++;
                        ack_log.push_back(h);
                        checkOutput(h == 0 ? "ack_a_owner" : "ack_b_owner", 32'(inflight), 32'(h));
                        if (qsize(h) == 0 || inflight != h) begin
                            checkOutput(h == 0 ? "ack_a_unexpected" : "ack_b_unexpected", 1, 0);
                        end else begin
                            e = (h == 0) ? qa.pop_front() : qb.pop_front();
                            checkOutput(h == 0 ? "a_dout" : "b_dout", 32'((h == 0) ? a_dout : b_dout), 32'(e.dout));
                            checkOutput("ack_latency_ok", 32'((n - gnt_n >= 4) && (n - gnt_n <= 12)), 1);
                            checkOutput("ctl_addr_stable", 32'(ctl_addr), 32'(held_addr));
                            checkOutput("ctl_din_stable", 32'(ctl_din), 32'(held_din));
                            inflight = -1;
                        end
                    end
                end
            end
        end
    end

    task automatic issueHost(input int h, input int op, input logic [23:0] ad,
                             input logic [15:0] dd, input bit drop);
        exp_t e;
        e.wr   = (op != 0);
        e.addr = ad;
        e.din  = dd;
        e.dout = e.wr ? last_dout[h] : (ad[15:0] ^ 16'hA5A5);
        prev_dout[h] = last_dout[h];
        last_dout[h] = e.dout;
        addr[h]  = ad;
        din[h]   = dd;
        rd_rq[h] = (op != 1);
        wr_rq[h] = (op != 0);
        if (h == 0) qa.push_back(e); else qb.push_back(e);
        hs_active[h] = 1;
        hs_wait[h]   = 0;
        hs_gnt[h]    = grant_cnt[h];
        hs_drop[h]   = drop;
    endtask

    // One negedge step of both host engines
    task automatic applyStimulus(input bit en, input bit cont, input bit rd_only);
        for (int h = 0; h < 2; h++) begin
            if (hs_active[h]) begin
                if (qsize(h) == 0) begin
                    rd_rq[h] = 0; wr_rq[h] = 0; hs_active[h] = 0;
                    hs_idle[h] = cont ? 0 : int'($urandom_range(6, 1));
                end else begin
                    hs_wait[h]++;
                    if (hs_wait[h] > 400) begin
                        checkOutput(h == 0 ? "timeout_a" : "timeout_b", 0, 1);
                        rd_rq[h] = 0; wr_rq[h] = 0; hs_active[h] = 0;
                        if (h == 0) qa.delete(); else qb.delete();
                    end else if (grant_cnt[h] != hs_gnt[h] && hs_drop[h]) begin
                        // drop early and scramble inputs; the op must still finish intact
                        rd_rq[h] = 0; wr_rq[h] = 0;
                        addr[h] = 24'($urandom); din[h] = 16'($urandom);
                    end else if (grant_cnt[h] == hs_gnt[h] && !en) begin
                        rd_rq[h] = 0; wr_rq[h] = 0; hs_active[h] = 0;
                        last_dout[h] = prev_dout[h];
                        if (h == 0) void'(qa.pop_back()); else void'(qb.pop_back());
                    end
                end
            end
            if (!hs_active[h] && en) begin
                if (hs_idle[h] > 0) hs_idle[h]--;
                else issueHost(h, rd_only ? 0 : int'($urandom_range(2, 0)), 24'($urandom),
                               16'($urandom), !cont && ($urandom_range(7, 0) == 0));
            end
        end
    endtask

    task automatic waitHost(input int h);
        int k;
        for (k = 0; k < 100 && qsize(h) != 0; k++) @(negedge clk);
        checkOutput(h == 0 ? "directed_a_done" : "directed_b_done", 32'(qsize(h)), 0);
        rd_rq[h] = 0; wr_rq[h] = 0; hs_active[h] = 0;
        if (h == 0) qa.delete(); else qb.delete();
    endtask

    task automatic drainHosts();
        for (int k = 0; k < 200 && (hs_active[0] || hs_active[1]); k++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0);
        end
        checkOutput("drain_done", 32'(hs_active[0] | hs_active[1]), 0);
    endtask

    initial begin
        int a0, w0, alt_ok, k;
        for (int h = 0; h < 2; h++) begin
            addr[h] = '0; din[h] = '0; rd_rq[h] = 0; wr_rq[h] = 0;
        end
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_rq", {ctl_read_rq, ctl_write_rq, ctl_rfsh_rq}, 0);
        checkOutput("rst_ctl_addr", 32'(ctl_addr), 0);
        checkOutput("rst_ctl_din", 32'(ctl_din), 0);
        checkOutput("rst_acks", {a_ack, b_ack}, 0);
        checkOutput("rst_douts", {a_dout, b_dout}, 0);
        checkOutput("rst_overflow", {rfsh_overflow, ovf2}, 0);

        // idle refresh cadence on dut, saturation on dut2 in parallel
        rst_n = 1; rst2_n = 1; busy2 = 1;
        for (int i = 1; i <= 210; i++) begin
            @(negedge clk);
            if (i == 30) begin
                checkOutput("sat_pending_7", 32'(dut2.pending), 7);
                checkOutput("sat_no_overflow_yet", 32'(ovf2), 0);
            end
            if (i == 100) begin
                checkOutput("sat_pending_held", 32'(dut2.pending), 7);
                checkOutput("sat_overflow", 32'(ovf2), 1);
                checkOutput("sat_no_rq_while_busy", {rd2, wr2, rf2}, 0);
                rst2_n = 0;
            end
            if (i == 101) begin
                checkOutput("sat_reset_pending", 32'(dut2.pending), 0);
                checkOutput("sat_reset_overflow", 32'(ovf2), 0);
                rst2_n = 1;
            end
        end
        checkOutput("idle_rfsh_count", 32'(rfsh_issued), 10);
        checkOutput("idle_no_acks", 32'(ack_cnt[0] + ack_cnt[1]), 0);
        checkOutput("idle_no_overflow", 32'(rfsh_overflow), 0);

        $display("[TB] directed host A write / host B read");
        w0 = wr_pulses; a0 = ack_cnt[0];
        issueHost(0, 1, 24'h000123, 16'h5555, 0);
        waitHost(0);
        checkOutput("a_write_pulses", 32'(wr_pulses - w0), 1);
        checkOutput("a_write_acks", 32'(ack_cnt[0] - a0), 1);
        a0 = ack_cnt[0];
        issueHost(1, 0, 24'h00FFFF, 16'h0000, 0);
        waitHost(1);
        checkOutput("b_read_dout", 32'(b_dout), 32'h5A5A);
        checkOutput("b_read_no_a_ack", 32'(ack_cnt[0] - a0), 0);

        $display("[TB] both hosts reading continuously");
        ack_log.delete();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            applyStimulus(1, 1, 1);
        end
        drainHosts();
        a0 = 0; alt_ok = 1;
        foreach (ack_log[i]) begin
            if (ack_log[i] == 0) a0++;
            if (i > 0 && ack_log[i] == ack_log[i-1]) alt_ok = 0;
        end
`ifdef SDRAM_ARB_RR_EN
        checkOutput("cont_alternates", 32'(alt_ok), 1);
        checkOutput("cont_enough_acks", 32'(ack_log.size() >= 6), 1);
`else
        checkOutput("cont_only_a", 32'(ack_log.size() - a0), 0);
        checkOutput("cont_enough_a", 32'(a0 >= 5), 1);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            applyStimulus(1, 0, 0);
        end
        drainHosts();
        repeat (2 * P1) @(negedge clk);
        for (k = 0; k < P1 && (n % P1) != 15; k++) @(negedge clk);
        checkOutput("rfsh_total", 32'(rfsh_issued), 32'(n / P1));
        checkOutput("rand_no_overflow", 32'(rfsh_overflow), 0);

        $display("[TB] reset during issue");
        issueHost(0, 0, 24'($urandom), 16'h0, 0);
        for (k = 0; k < 100 && grant_cnt[0] == hs_gnt[0]; k++) @(negedge clk);
        checkOutput("mid_reset_granted", 32'(grant_cnt[0] != hs_gnt[0]), 1);
        rst_n = 0;
        rd_rq[0] = 0; wr_rq[0] = 0; hs_active[0] = 0;
        qa.delete(); qb.delete();
        last_dout[0] = '0; last_dout[1] = '0;
        a0 = ack_cnt[0];
        @(negedge clk);
        checkOutput("mid_reset_rq_low", {ctl_read_rq, ctl_write_rq, ctl_rfsh_rq}, 0);
        checkOutput("mid_reset_ctl_addr", 32'(ctl_addr), 0);
        rst_n = 1;
        repeat (25) @(negedge clk);
        checkOutput("mid_reset_no_ack", 32'(ack_cnt[0] - a0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
